// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the memory port arbiter.
package mem_arb_pkg;

   // Dump sequencing states; IDLE is the only state that grants traffic.
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      DRAIN = 2'd1,
      DUMP  = 2'd2,
      DONE  = 2'd3
   } arb_state_t;

   // Requester ids stored with an in-flight read.
   localparam logic REQ_IF = 1'b0;
   localparam logic REQ_D  = 1'b1;

   // Low address bits that must be zero for a word access.
   localparam logic [31:0] WORD_ALIGN_MASK = 32'h0000_0003;

   function automatic logic is_misaligned(input logic [31:0] addr);
      return (addr & WORD_ALIGN_MASK) != 32'h0;
   endfunction

endpackage

// File: rtl/mem_arb_wait_ctr.sv
// Saturating fetch starvation counter: counts cycles a pending fetch loses.
module mem_arb_wait_ctr #(
   parameter int MAX_WAIT = 4,
   parameter int CW       = $clog2(MAX_WAIT + 1)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          i_req,
   input  logic          i_grant,
   output logic [CW-1:0] o_cnt
);

   localparam logic [CW-1:0] MAX_W = CW'(MAX_WAIT);

   logic [CW-1:0] r_cnt;

   // Clear on grant, count up while the fetch is waiting, hold otherwise.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt <= '0;
      end else if (i_grant) begin
         r_cnt <= '0;
      end else if (i_req && (r_cnt != MAX_W)) begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

   assign o_cnt = r_cnt;

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port word memory between instruction fetch and data
// access, with data priority, a fetch starvation guard and dump sequencing.
//
// Handshake: a request is accepted in the cycle where req & ready are both
// high; ready is combinational from req, FSM state and the wait counter.
// Read data returns on rvalid, READ_LAT cycles after acceptance.
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int READ_LAT = 1,
   parameter int MAX_WAIT = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        if_req,
   input  logic [31:0] if_addr,
   output logic        if_ready,
   output logic        if_rvalid,
   output logic [31:0] if_rdata,
   output logic        if_err,
   input  logic        d_req,
   input  logic        d_wr,
   input  logic [31:0] d_addr,
   input  logic [31:0] d_wdata,
   output logic        d_ready,
   output logic        d_rvalid,
   output logic [31:0] d_rdata,
   output logic        d_err,
   output logic        mem_enable,
   output logic        mem_wr,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_data_in,
   input  logic [31:0] mem_data_out,
   input  logic        dump_req,
   output logic        mem_createdump,
   output logic        dump_done,
   output logic [1:0]  dbg_state
);

   localparam int            CW    = $clog2(MAX_WAIT + 1);
   localparam logic [CW-1:0] MAX_W = CW'(MAX_WAIT);

   arb_state_t    r_state;
   logic          r_rd_valid;
   logic          r_rd_id;
   logic [CW-1:0] w_wait_cnt;
   logic          w_grant_ok;
   logic          w_d_win;
   logic          w_if_win;
   logic          w_d_go;
   logic          w_if_go;
   logic          w_rd_acc;

   mem_arb_wait_ctr #(
      .MAX_WAIT (MAX_WAIT),
      .CW       (CW)
   ) u_wait_ctr (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_req   (if_req),
      .i_grant (w_if_win),
      .o_cnt   (w_wait_cnt)
   );

   // Arbitration: data wins unless the fetch has waited MAX_WAIT cycles;
   // a dump request in IDLE blocks every grant in that cycle.
   always_comb begin
      w_grant_ok = rst_n && (r_state == IDLE) && !dump_req;
      w_d_win    = w_grant_ok && d_req && (w_wait_cnt < MAX_W);
      w_if_win   = w_grant_ok && if_req && !w_d_win;
      w_d_go     = w_d_win && !is_misaligned(d_addr);
      w_if_go    = w_if_win && !is_misaligned(if_addr);
      w_rd_acc   = (w_d_go && !d_wr) || w_if_go;
   end

   assign d_ready  = w_d_win;
   assign if_ready = w_if_win;
   assign d_err    = w_d_win && is_misaligned(d_addr);
   assign if_err   = w_if_win && is_misaligned(if_addr);

   // Memory port drive from the aligned winner; idle port is all zeros.
   always_comb begin
      mem_enable  = 1'b0;
      mem_wr      = 1'b0;
      mem_addr    = 32'h0;
      mem_data_in = 32'h0;
      if (w_d_go) begin
         mem_enable  = 1'b1;
         mem_wr      = d_wr;
         mem_addr    = d_addr;
         mem_data_in = d_wdata;
      end else if (w_if_go) begin
         mem_enable  = 1'b1;
         mem_addr    = if_addr;
      end
   end

   // In-flight read owner; only used when the memory has a latency stage.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rd_valid <= 1'b0;
         r_rd_id    <= REQ_IF;
      end else begin
         r_rd_valid <= (READ_LAT != 0) && w_rd_acc;
         if (w_rd_acc) begin
            r_rd_id <= w_d_go ? REQ_D : REQ_IF;
         end
      end
   end

   // Route read data to its owner; the non-owner sees zero.
   always_comb begin
      if (READ_LAT == 0) begin
         d_rvalid  = w_d_go && !d_wr;
         if_rvalid = w_if_go;
      end else begin
         d_rvalid  = r_rd_valid && (r_rd_id == REQ_D);
         if_rvalid = r_rd_valid && (r_rd_id == REQ_IF);
      end
      d_rdata  = d_rvalid  ? mem_data_out : 32'h0;
      if_rdata = if_rvalid ? mem_data_out : 32'h0;
   end

   // Dump sequencer: drain in-flight reads, strobe the dump, report done.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
      end else begin
         case (r_state)
            IDLE:    if (dump_req) r_state <= DRAIN;
            DRAIN:   if (!r_rd_valid) r_state <= DUMP;
            DUMP:    r_state <= DONE;
            DONE:    r_state <= IDLE;
            default: r_state <= IDLE;
         endcase
      end
   end

   assign mem_createdump = (r_state == DUMP);
   assign dump_done      = (r_state == DONE);
   assign dbg_state      = r_state;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter (READ_LAT=1, MAX_WAIT=4).
module tb_mem_port_arbiter;

   localparam int READ_LAT = 1;
   localparam int MAX_WAIT = 4;

   logic        clk;
   logic        rst_n;
   logic        if_req;
   logic [31:0] if_addr;
   logic        if_ready;
   logic        if_rvalid;
   logic [31:0] if_rdata;
   logic        if_err;
   logic        d_req;
   logic        d_wr;
   logic [31:0] d_addr;
   logic [31:0] d_wdata;
   logic        d_ready;
   logic        d_rvalid;
   logic [31:0] d_rdata;
   logic        d_err;
   logic        mem_enable;
   logic        mem_wr;
   logic [31:0] mem_addr;
   logic [31:0] mem_data_in;
   logic [31:0] mem_data_out;
   logic        dump_req;
   logic        mem_createdump;
   logic        dump_done;
   logic [1:0]  dbg_state;

   int          n_checks = 0;
   int          n_fail   = 0;
   int          cyc      = 0;
   logic [31:0] d_exp_q[$];
   logic [31:0] if_exp_q[$];
   bit          d_rd_at[0:4095];
   bit          if_rd_at[0:4095];
   logic [31:0] mem_arr[0:255];
   logic [31:0] ref_mem[0:255];

   mem_port_arbiter #(
      .READ_LAT (READ_LAT),
      .MAX_WAIT (MAX_WAIT)
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .if_req         (if_req),
      .if_addr        (if_addr),
      .if_ready       (if_ready),
      .if_rvalid      (if_rvalid),
      .if_rdata       (if_rdata),
      .if_err         (if_err),
      .d_req          (d_req),
      .d_wr           (d_wr),
      .d_addr         (d_addr),
      .d_wdata        (d_wdata),
      .d_ready        (d_ready),
      .d_rvalid       (d_rvalid),
      .d_rdata        (d_rdata),
      .d_err          (d_err),
      .mem_enable     (mem_enable),
      .mem_wr         (mem_wr),
      .mem_addr       (mem_addr),
      .mem_data_in    (mem_data_in),
      .mem_data_out   (mem_data_out),
      .dump_req       (dump_req),
      .mem_createdump (mem_createdump),
      .dump_done      (dump_done),
      .dbg_state      (dbg_state)
   );

   // Clock and cycle counter
   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Memory macro model with one cycle of read latency
   always @(posedge clk) begin
      if (mem_enable) begin
         if (mem_wr) mem_arr[mem_addr[9:2]] <= mem_data_in;
         else        mem_data_out <= mem_arr[mem_addr[9:2]];
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Data driver: holds the request until accepted, then records expectations
   task automatic d_access(input logic wr, input logic [31:0] addr,
                           input logic [31:0] wdata, output int waited);
      bit acc = 0;
      logic [1:0] lo;
      lo = addr[1:0];
      d_req = 1'b1; d_wr = wr; d_addr = addr; d_wdata = wdata;
      waited = 0;
      while (!acc && waited < 20) begin
         @(negedge clk);
         waited++;
         if (d_ready) acc = 1;
      end
      if (!acc) begin
         check("d_ready_timeout", 32'd0, 32'd1);
      end else begin
         check("d_err", d_err, (lo != 2'b00));
         check("d_mem_en", mem_enable, (lo == 2'b00));
         check("d_one_grant", if_ready, 32'd0);
         if (lo == 2'b00) begin
            check("d_mem_addr", mem_addr, addr);
            check("d_mem_wr", mem_wr, wr);
            if (wr) begin
               check("d_mem_wdata", mem_data_in, wdata);
               ref_mem[addr[9:2]] = wdata;
            end else begin
               d_exp_q.push_back(ref_mem[addr[9:2]]);
               d_rd_at[cyc] = 1'b1;
            end
         end
      end
      @(posedge clk); #1;
      d_req = 1'b0;
   endtask

   // Fetch driver
   task automatic if_access(input logic [31:0] addr, output int waited);
      bit acc = 0;
      logic [1:0] lo;
      lo = addr[1:0];
      if_req = 1'b1; if_addr = addr;
      waited = 0;
      while (!acc && waited < 20) begin
         @(negedge clk);
         waited++;
         if (if_ready) acc = 1;
      end
      if (!acc) begin
         check("if_ready_timeout", 32'd0, 32'd1);
      end else begin
         check("if_err", if_err, (lo != 2'b00));
         check("if_mem_en", mem_enable, (lo == 2'b00));
         check("if_one_grant", d_ready, 32'd0);
         if (lo == 2'b00) begin
            check("if_mem_addr", mem_addr, addr);
            check("if_mem_wr", mem_wr, 32'd0);
            if_exp_q.push_back(ref_mem[addr[9:2]]);
            if_rd_at[cyc] = 1'b1;
         end
      end
      @(posedge clk); #1;
      if_req = 1'b0;
   endtask

   // Scoreboard monitor: rvalid must follow each accepted read by one cycle
   always @(negedge clk) begin : mon
      bit exp_d;
      bit exp_i;
      if (cyc > 0) begin
         exp_d = d_rd_at[cyc-1] && rst_n;
         exp_i = if_rd_at[cyc-1] && rst_n;
         if (exp_d || d_rvalid) check("d_rvalid", d_rvalid, exp_d);
         if (exp_i || if_rvalid) check("if_rvalid", if_rvalid, exp_i);
         if (d_rvalid) begin
            if (d_exp_q.size() == 0) check("d_rdata_unexpected", 32'd1, 32'd0);
            else check("d_rdata", d_rdata, d_exp_q.pop_front());
            check("if_rdata_nonowner", if_rdata, 32'd0);
         end else if (exp_d && d_exp_q.size() > 0) begin
            void'(d_exp_q.pop_front());
         end
         if (if_rvalid) begin
            if (if_exp_q.size() == 0) check("if_rdata_unexpected", 32'd1, 32'd0);
            else check("if_rdata", if_rdata, if_exp_q.pop_front());
            check("d_rdata_nonowner", d_rdata, 32'd0);
         end else if (exp_i && if_exp_q.size() > 0) begin
            void'(if_exp_q.pop_front());
         end
      end
   end

   // One dump-sequence cycle: no grants, strobes as given
   task automatic dump_step(input string name, input logic exp_create, input logic exp_done);
      @(negedge clk);
      check({name, "_if_ready"}, if_ready, 32'd0);
      check({name, "_mem_en"}, mem_enable, 32'd0);
      check({name, "_createdump"}, mem_createdump, exp_create);
      check({name, "_dump_done"}, dump_done, exp_done);
      @(posedge clk); #1;
      dump_req = 1'b0;
   endtask

   // Global time limit
   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   // Directed stimulus
   initial begin
      int w1;
      int w2;
      for (int i = 0; i < 256; i++) begin
         mem_arr[i] = 32'hC0DE_0000 | i;
         ref_mem[i] = 32'hC0DE_0000 | i;
      end
      rst_n = 1'b0; if_req = 1'b0; if_addr = 32'h0; d_req = 1'b0; d_wr = 1'b0;
      d_addr = 32'h0; d_wdata = 32'h0; dump_req = 1'b0; mem_data_out = 32'h0;

      // Reset state, even with a request pending
      repeat (2) @(posedge clk);
      #1; d_req = 1'b1; d_addr = 32'h10;
      @(negedge clk);
      check("rst_d_ready", d_ready, 32'd0);
      check("rst_if_ready", if_ready, 32'd0);
      check("rst_mem_en", mem_enable, 32'd0);
      check("rst_mem_addr", mem_addr, 32'd0);
      check("rst_createdump", mem_createdump, 32'd0);
      check("rst_dump_done", dump_done, 32'd0);
      check("rst_d_rvalid", d_rvalid, 32'd0);
      @(posedge clk); #1;
      d_req = 1'b0; rst_n = 1'b1;
      @(posedge clk); #1;

      // Data priority, then the starved fetch is forced through
      fork
         begin
            for (int k = 0; k < 5; k++) begin
               d_access(1'b0, 32'h10, 32'h0, w1);
               if (k == 0) check("d_first_wait", w1, 32'd1);
            end
         end
         begin
            if_access(32'h20, w2);
            check("if_starve_bound", (w2 <= MAX_WAIT + 1), 32'd1);
            check("if_starve_wait", w2, MAX_WAIT + 1);
         end
      join

      // Continuous writes vs held fetch: one fetch grant every 5 cycles
      fork
         begin
            for (int k = 0; k < 16; k++)
               d_access(1'b1, 32'h40 + 4 * k, 32'h1234_0000 + k, w1);
         end
         begin
            for (int j = 0; j < 4; j++) begin
               if_access(32'h24, w2);
               check("if_period", w2, 32'd5);
            end
         end
      join

      // Write then read back
      d_access(1'b1, 32'h8, 32'hDEAD_BEEF, w1);
      d_access(1'b0, 32'h8, 32'h0, w1);
      check("ref_deadbeef", ref_mem[2], 32'hDEAD_BEEF);
      d_access(1'b0, 32'h44, 32'h0, w1);

      // Misaligned requests
      if_access(32'h6, w2);
      d_access(1'b0, 32'h11, 32'h0, w1);
      @(posedge clk); #1;

      // Dump right after an accepted read, with a fetch waiting
      d_access(1'b0, 32'h10, 32'h0, w1);
      dump_req = 1'b1; if_req = 1'b1; if_addr = 32'h20;
      dump_step("dump_req_cyc", 1'b0, 1'b0);
      dump_step("drain", 1'b0, 1'b0);
      dump_step("dump", 1'b1, 1'b0);
      dump_step("done", 1'b0, 1'b1);
      @(negedge clk);
      check("post_dump_if_ready", if_ready, 32'd1);
      check("post_dump_mem_en", mem_enable, 32'd1);
      check("post_dump_createdump", mem_createdump, 32'd0);
      if (if_ready) begin
         if_exp_q.push_back(ref_mem[8]);
         if_rd_at[cyc] = 1'b1;
      end
      @(posedge clk); #1;
      if_req = 1'b0;
      repeat (2) @(posedge clk);
      #1;

      // Reset the cycle after a read is accepted: the response is dropped
      d_req = 1'b1; d_wr = 1'b0; d_addr = 32'h14;
      @(negedge clk);
      check("pre_rst_d_ready", d_ready, 32'd1);
      @(posedge clk); #1;
      d_req = 1'b0; rst_n = 1'b0;
      @(negedge clk);
      check("mid_rst_d_rvalid", d_rvalid, 32'd0);
      check("mid_rst_d_rdata", d_rdata, 32'd0);
      check("mid_rst_if_rvalid", if_rvalid, 32'd0);
      check("mid_rst_mem_en", mem_enable, 32'd0);
      check("mid_rst_dump_done", dump_done, 32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("post_rst_d_rvalid", d_rvalid, 32'd0);

      check("d_q_drained", d_exp_q.size(), 32'd0);
      check("if_q_drained", if_exp_q.size(), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
